// File: rtl/dtw_word_sched.sv
// dtw_word_sched: collects recognized characters into a 15-byte word, fetches
// the matching dictionary bucket (one bucket per lowercase first letter),
// launches the DTW engine on the word plus candidates, and returns the best
// match or an error.
//
// Ports
//   i_DTW_clk, i_DTW_rst_n      clock, synchronous active-low reset
//   i_char_valid/i_char         incoming character (byte 0 of the word first)
//   i_word_end                  closes the current word
//   o_busy                      high whenever not collecting characters
//   o_dict_rd/o_dict_addr       dictionary read strobe and row address
//   i_dict_data                 dictionary row, one cycle after o_dict_rd
//   o_dtw_start                 one-cycle DTW launch pulse
//   o_dtw_word/o_dtw_cand       DTW operands, row r at [r*120 +: 120]
//   i_dtw_finish/i_dtw_word     DTW done pulse and best match
//   o_word_valid/o_word         result pulse, result held until next result
//   o_error                     one-cycle error pulse (bad first char, timeout)
//   o_dbg_state                 current FSM state
//
// Handshakes: there is no back-pressure anywhere. Every *_valid, *_start,
// *_finish, *_rd and *_end signal is a strobe that is consumed in the cycle it
// is high (if the FSM is in a state that listens for it) and is otherwise
// ignored; data travels in the same cycle as its strobe, except dictionary
// data which follows o_dict_rd by exactly one cycle.
module dtw_word_sched #(
  parameter int DICT_ROWS = 20,
  parameter int TIMEOUT   = 1023
) (
  input  logic                     i_DTW_clk,
  input  logic                     i_DTW_rst_n,
  input  logic                     i_char_valid,
  input  logic [7:0]               i_char,
  input  logic                     i_word_end,
  output logic                     o_busy,
  output logic                     o_dict_rd,
  output logic [9:0]               o_dict_addr,
  input  logic [119:0]             i_dict_data,
  output logic                     o_dtw_start,
  output logic [119:0]             o_dtw_word,
  output logic [DICT_ROWS*120-1:0] o_dtw_cand,
  input  logic                     i_dtw_finish,
  input  logic [119:0]             i_dtw_word,
  output logic                     o_word_valid,
  output logic [119:0]             o_word,
  output logic                     o_error,
  output logic [2:0]               o_dbg_state
);

  // Fetch counter runs 0..DICT_ROWS: reads on 0..DICT_ROWS-1, the extra
  // cycle lets the last row land.
  localparam int FCW = $clog2(DICT_ROWS + 1);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_FETCH   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [119:0]             word_q, word_app;
  logic [3:0]               k_q, k_app;
  logic [9:0]               base_q, base_d;
  logic [FCW-1:0]           fetch_cnt_q;
  logic [9:0]               wait_cnt_q;
  logic [DICT_ROWS*120-1:0] cand_q;
  logic [119:0]             word_out_q;
  logic                     err_q;
  logic                     first_ok;
  logic                     word_go;
  logic                     word_bad;
  logic                     dtw_timeout;

  // Buffer as it would look after this cycle's character. A same-cycle word
  // end sees the appended character. Zero bytes mark empty slots, so a zero
  // character is never stored.
  always_comb begin
    word_app = word_q;
    k_app    = k_q;
    if (i_char_valid && (i_char != 8'h00) && (k_q != 4'd15)) begin
      word_app[{k_q, 3'b000} +: 8] = i_char;
      k_app                        = k_q + 4'd1;
    end
    first_ok = (word_app[7:0] >= 8'h61) && (word_app[7:0] <= 8'h7a);
    word_go  = (state_q == S_COLLECT) && i_word_end && (k_app != 4'd0) && first_ok;
    word_bad = (state_q == S_COLLECT) && i_word_end && (k_app != 4'd0) && !first_ok;
    base_d   = ({2'b00, word_app[7:0]} - 10'h061) * 10'(DICT_ROWS);
    // A finish on the timeout cycle takes priority over the timeout.
    dtw_timeout = (state_q == S_WAIT) && !i_dtw_finish && (wait_cnt_q == 10'(TIMEOUT));
  end

  always_ff @(posedge i_DTW_clk) begin
    if (!i_DTW_rst_n) state_q <= S_COLLECT;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (word_go) state_d = S_FETCH;
      S_FETCH:   if (fetch_cnt_q == FCW'(DICT_ROWS)) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (i_dtw_finish)     state_d = S_OUT;
        else if (dtw_timeout) state_d = S_COLLECT;
      end
      S_OUT:     state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_DTW_clk) begin
    if (!i_DTW_rst_n) begin
      word_q      <= '0;
      k_q         <= '0;
      base_q      <= '0;
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
      cand_q      <= '0;
      word_out_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= word_bad || dtw_timeout;
      case (state_q)
        S_COLLECT: begin
          fetch_cnt_q <= '0;
          if (word_bad) begin
            word_q <= '0;
            k_q    <= '0;
          end else begin
            // On a good word end the buffer keeps the word for the DTW run.
            word_q <= word_app;
            k_q    <= k_app;
          end
          if (word_go) base_q <= base_d;
        end
        S_FETCH: begin
          fetch_cnt_q <= fetch_cnt_q + FCW'(1);
          // Row n was read while the counter was n; it arrives at n+1.
          for (int r = 0; r < DICT_ROWS; r++) begin
            if (fetch_cnt_q == FCW'(r + 1)) cand_q[r*120 +: 120] <= i_dict_data;
          end
        end
        S_START: wait_cnt_q <= '0;
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 10'd1;
          if (i_dtw_finish) begin
            word_out_q <= i_dtw_word;
          end else if (dtw_timeout) begin
            word_q <= '0;
            k_q    <= '0;
          end
        end
        S_OUT: begin
          word_q <= '0;
          k_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (state_q != S_COLLECT);
  assign o_dict_rd    = (state_q == S_FETCH) && (fetch_cnt_q < FCW'(DICT_ROWS));
  assign o_dict_addr  = o_dict_rd ? (base_q + 10'(fetch_cnt_q)) : 10'd0;
  assign o_dtw_start  = (state_q == S_START);
  assign o_dtw_word   = word_q;
  assign o_dtw_cand   = cand_q;
  assign o_word_valid = (state_q == S_OUT);
  assign o_word       = word_out_q;
  assign o_error      = err_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_dtw_word_sched.sv
// Bench for dtw_word_sched: directed scenarios plus random words, checked
// against a word-level model (stored bytes, bucket base, expected result
// timing) and a dictionary RAM model.
module tb_dtw_word_sched;
  localparam int DICT_ROWS = 20;
  localparam int TIMEOUT   = 1023;

  // ---------------- clock / reset ----------------
  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     i_char_valid, i_word_end, i_dtw_finish;
  logic [7:0]               i_char;
  logic [119:0]             i_dict_data, i_dtw_word;
  logic                     o_busy, o_dict_rd, o_dtw_start, o_word_valid, o_error;
  logic [9:0]               o_dict_addr;
  logic [119:0]             o_dtw_word, o_word;
  logic [DICT_ROWS*120-1:0] o_dtw_cand;
  logic [2:0]               o_dbg_state;

  always #5 clk = ~clk;

  dtw_word_sched #(.DICT_ROWS(DICT_ROWS), .TIMEOUT(TIMEOUT)) dut (
    .i_DTW_clk    (clk),
    .i_DTW_rst_n  (rst_n),
    .i_char_valid (i_char_valid),
    .i_char       (i_char),
    .i_word_end   (i_word_end),
    .o_busy       (o_busy),
    .o_dict_rd    (o_dict_rd),
    .o_dict_addr  (o_dict_addr),
    .i_dict_data  (i_dict_data),
    .o_dtw_start  (o_dtw_start),
    .o_dtw_word   (o_dtw_word),
    .o_dtw_cand   (o_dtw_cand),
    .i_dtw_finish (i_dtw_finish),
    .i_dtw_word   (i_dtw_word),
    .o_word_valid (o_word_valid),
    .o_word       (o_word),
    .o_error      (o_error),
    .o_dbg_state  (o_dbg_state)
  );

  // Dictionary RAM: data one cycle after the read strobe.
  logic [119:0] dict_mem [1024];
  always @(posedge clk) if (o_dict_rd) i_dict_data <= dict_mem[o_dict_addr];

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [119:0] exp_q[$];        // expected dictionary addresses
  logic [119:0] exp_word_out;    // expected held o_word
  logic [7:0]   cur_chars[$];    // characters of the word under test

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] rand_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[119:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  120'(o_busy), 120'(0));
    check({tag, "_rd"},    120'(o_dict_rd), 120'(0));
    check({tag, "_addr"},  120'(o_dict_addr), 120'(0));
    check({tag, "_start"}, 120'(o_dtw_start), 120'(0));
    check({tag, "_valid"}, 120'(o_word_valid), 120'(0));
    check({tag, "_err"},   120'(o_error), 120'(0));
    check({tag, "_dword"}, o_dtw_word, 120'(0));
    check({tag, "_word"},  o_word, 120'(0));
    check({tag, "_state"}, 120'(o_dbg_state), 120'(0));
    for (int r = 0; r < DICT_ROWS; r++) check({tag, "_cand"}, o_dtw_cand[r*120 +: 120], 120'(0));
  endtask

  // ---------------- driver + model ----------------
  // Feeds cur_chars (end merged with the last char if merged), then follows
  // the word through fetch and DTW. d = wait-cycle index of the finish pulse
  // (d > TIMEOUT means the engine never answers). abort_at >= 0 asserts
  // reset at that fetch cycle.
  task automatic process(input bit merged, input int d, input logic [119:0] fw, input int abort_at);
    logic [119:0] eb;
    int k, base, st, nrd, v_idx, e_idx, lim;
    eb = '0; k = 0; st = -1; nrd = 0; v_idx = -1; e_idx = -1;
    foreach (cur_chars[i]) begin
      if (cur_chars[i] != 8'h00 && k < 15) begin
        eb[8*k +: 8] = cur_chars[i];
        k++;
      end
    end

    foreach (cur_chars[i]) begin
      @(negedge clk);
      check("collect_busy", 120'(o_busy), 120'(0));
      i_char_valid = 1'b1;
      i_char       = cur_chars[i];
      i_word_end   = merged && (i == cur_chars.size() - 1);
    end
    if (!merged || cur_chars.size() == 0) begin
      @(negedge clk);
      i_char_valid = 1'b0;
      i_word_end   = 1'b1;
    end
    @(negedge clk);
    i_char_valid = 1'b0;
    i_word_end   = 1'b0;
    i_char       = 8'h00;

    if (k == 0) begin
      repeat (3) begin
        check("empty_busy", 120'(o_busy), 120'(0));
        check("empty_err", 120'(o_error), 120'(0));
        @(negedge clk);
      end
      return;
    end

    if (eb[7:0] < 8'h61 || eb[7:0] > 8'h7a) begin
      check("bad_err", 120'(o_error), 120'(1));
      check("bad_busy", 120'(o_busy), 120'(0));
      check("bad_clear", o_dtw_word, 120'(0));
      check("bad_rd", 120'(o_dict_rd), 120'(0));
      @(negedge clk);
      check("bad_err_once", 120'(o_error), 120'(0));
      check("bad_rd2", 120'(o_dict_rd), 120'(0));
      check("bad_busy2", 120'(o_busy), 120'(0));
      return;
    end

    base = (int'(eb[7:0]) - 'h61) * DICT_ROWS;
    exp_q.delete();
    for (int n = 0; n < DICT_ROWS; n++) exp_q.push_back(120'(base + n));
    check("fetch_first_rd", 120'(o_dict_rd), 120'(1));
    for (int idx = 0; idx < DICT_ROWS + 8; idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst_n        = 1'b1;
        exp_word_out = '0;
        exp_q.delete();
        return;
      end
      i_dtw_finish = 1'($urandom_range(0, 1));   // must be ignored here
      if (o_dict_rd) begin
        if (exp_q.size() > 0) check("fetch_addr", 120'(o_dict_addr), exp_q.pop_front());
        else                  check("fetch_extra_rd", 120'(o_dict_rd), 120'(0));
        nrd++;
      end
      if (o_dtw_start) begin
        st = idx;
        break;
      end
    end
    i_dtw_finish = 1'b0;
    check("fetch_nrd", 120'(nrd), 120'(DICT_ROWS));
    check("start_idx", 120'(st), 120'(DICT_ROWS + 1));
    exp_q.delete();
    if (st < 0) return;
    check("start_word", o_dtw_word, eb);
    for (int r = 0; r < DICT_ROWS; r++)
      check("cand_row", o_dtw_cand[r*120 +: 120], dict_mem[base + r]);

    lim = (d < TIMEOUT) ? d : TIMEOUT;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      @(negedge clk);
      i_dtw_finish = (c == d);
      i_dtw_word   = (c == d) ? fw : rand_word();
      i_char_valid = (c < lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_word_end   = (c < lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_char       = 8'($urandom_range(8'h61, 8'h7a));
      if (c == 0) begin
        check("wait_start_once", 120'(o_dtw_start), 120'(0));
        check("wait_rd", 120'(o_dict_rd), 120'(0));
        check("wait_busy", 120'(o_busy), 120'(1));
      end
      if (o_word_valid) begin v_idx = c; break; end
      if (o_error)      begin e_idx = c; break; end
    end
    i_dtw_finish = 1'b0;
    i_char_valid = 1'b0;
    i_word_end   = 1'b0;

    if (d <= TIMEOUT) begin
      check("valid_idx", 120'(v_idx), 120'(d + 1));
      check("valid_no_err", 120'(e_idx), 120'(-1));
      check("valid_word", o_word, fw);
      check("valid_dword_stable", o_dtw_word, eb);
      exp_word_out = fw;
    end else begin
      check("timeout_idx", 120'(e_idx), 120'(TIMEOUT + 1));
      check("timeout_no_valid", 120'(v_idx), 120'(-1));
      check("timeout_word_held", o_word, exp_word_out);
      check("timeout_clear", o_dtw_word, 120'(0));
      check("timeout_busy", 120'(o_busy), 120'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) dict_mem[i] = rand_word();
    i_char_valid = 1'b0; i_word_end = 1'b0; i_char = 8'h00;
    i_dtw_finish = 1'b0; i_dtw_word = '0;
    exp_word_out = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // "cat", answer "cat" 30 cycles after start
    cur_chars = '{8'h63, 8'h61, 8'h74};
    process(1'b0, 29, 120'h746163, -1);
    // 17 x 'a': only 15 stored, bucket 0
    cur_chars.delete();
    repeat (17) cur_chars.push_back(8'h61);
    process(1'b0, 5, rand_word(), -1);
    // non-letter first character
    cur_chars = '{8'h31};
    process(1'b0, 0, '0, -1);
    // empty word end
    cur_chars.delete();
    process(1'b0, 0, '0, -1);
    // last bucket, zero char dropped, end merged with last char
    cur_chars = '{8'h7a, 8'h00, 8'h6f, 8'h6f};
    process(1'b1, 12, rand_word(), -1);
    // engine never answers, then answers exactly on the timeout cycle
    cur_chars = '{8'h64, 8'h6f, 8'h67};
    process(1'b0, TIMEOUT + 5, rand_word(), -1);
    process(1'b0, TIMEOUT, rand_word(), -1);
    // reset in the middle of the fetch, then a normal word
    process(1'b0, 0, '0, 6);
    cur_chars = '{8'h63, 8'h61, 8'h74};
    process(1'b0, 0, rand_word(), -1);

    for (int w = 0; w < 10; w++) begin
      int len;
      len = $urandom_range(1, 18);
      cur_chars.delete();
      if ($urandom_range(0, 5) == 0) cur_chars.push_back(8'($urandom_range(8'h21, 8'h60)));
      else                           cur_chars.push_back(8'($urandom_range(8'h61, 8'h7a)));
      for (int j = 1; j < len; j++)
        cur_chars.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8'h61, 8'h7a)));
      process(1'($urandom_range(0, 1)), $urandom_range(0, 60), rand_word(), -1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
